// File: rtl/gyro_pkg.sv
// gyro_pkg
//   Shared definitions for the gyro servo filter: the controller state type
//   and the default values of every block parameter, including the servo
//   clamp limits.
package gyro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAL  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_CH       = 2;
  localparam int DEF_ALPHA_SH = 2;
  localparam int DEF_CAL_LOG2 = 4;
  localparam int DEF_OUT_MIN  = -1000;
  localparam int DEF_OUT_MAX  = 1000;

endpackage

// File: rtl/gyro_servo_filter_if.sv
// gyro_servo_filter_if
//   Bundles the control, gyro sample and servo command signals of
//   gyro_servo_filter.
//   master : the controlling side (drives enable, cal_start, gyro_valid,
//            gyro_data; observes the servo/status outputs)
//   slave  : the filter itself
//   Signals:
//     enable, cal_start, gyro_valid  control / sample strobe
//     gyro_data  [CH*DATA_W]          packed signed samples, ch i at [i*DATA_W +: DATA_W]
//     servo_out  [CH*DATA_W]          packed signed clamped servo commands
//     servo_valid                     one-cycle strobe, servo_out updated
//     sat        [CH]                 per-channel clamp flag
//     cal_busy, cal_done              calibration status
interface gyro_servo_filter_if
  import gyro_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CH     = DEF_CH
);
  logic                 enable;
  logic                 cal_start;
  logic                 gyro_valid;
  logic [CH*DATA_W-1:0] gyro_data;
  logic [CH*DATA_W-1:0] servo_out;
  logic                 servo_valid;
  logic [CH-1:0]        sat;
  logic                 cal_busy;
  logic                 cal_done;

  modport master (
    output enable, cal_start, gyro_valid, gyro_data,
    input  servo_out, servo_valid, sat, cal_busy, cal_done
  );

  modport slave (
    input  enable, cal_start, gyro_valid, gyro_data,
    output servo_out, servo_valid, sat, cal_busy, cal_done
  );
endinterface

// File: rtl/gyro_chan_filter.sv
// gyro_chan_filter
//   One channel of the servo datapath: calibration accumulator and offset,
//   offset subtraction, first-order IIR low-pass and output clamp.
//   Ports:
//     clk, reset      clock, asynchronous active-low reset
//     sample_i        signed gyro sample for this channel
//     acc_clr_i       restart calibration (clear accumulator)
//     acc_en_i        accumulate sample_i into the calibration sum
//     cal_fin_i       with acc_en_i: last calibration sample, latch offset
//                     and clear the filter state
//     run_en_i        filter sample_i (stage p1 update)
//     out_en_i        load the clamped filter value into the output (p2)
//     out_clr_i       force the output and sat flag to zero
//     servo_o, sat_o  clamped servo command and clamp flag
module gyro_chan_filter
  import gyro_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ALPHA_SH = DEF_ALPHA_SH,
  parameter int CAL_LOG2 = DEF_CAL_LOG2,
  parameter int OUT_MIN  = DEF_OUT_MIN,
  parameter int OUT_MAX  = DEF_OUT_MAX
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] sample_i,
  input  logic                     acc_clr_i,
  input  logic                     acc_en_i,
  input  logic                     cal_fin_i,
  input  logic                     run_en_i,
  input  logic                     out_en_i,
  input  logic                     out_clr_i,
  output logic signed [DATA_W-1:0] servo_o,
  output logic                     sat_o
);

  localparam int AW  = DATA_W + CAL_LOG2;
  localparam int XW  = DATA_W + 1;
  localparam int DW2 = DATA_W + 2;

  localparam logic signed [XW-1:0] LIM_LO = XW'(OUT_MIN);
  localparam logic signed [XW-1:0] LIM_HI = XW'(OUT_MAX);

  function automatic logic signed [DATA_W-1:0] clamp_fn(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] r;
    if (v < LIM_LO)      r = LIM_LO;
    else if (v > LIM_HI) r = LIM_HI;
    else                 r = v;
    return r[DATA_W-1:0];
  endfunction

  function automatic logic sat_fn(input logic signed [XW-1:0] v);
    return (v < LIM_LO) || (v > LIM_HI);
  endfunction

  logic signed [AW-1:0]     acc_q, acc_d, acc_sum;
  logic signed [DATA_W-1:0] off_q, off_d;
  logic signed [XW-1:0]     x_p0;
  logic signed [DW2-1:0]    diff_p0, step_p0, ynew_p0;
  logic signed [XW-1:0]     y_p1_q, y_p1_d;
  logic signed [DATA_W-1:0] servo_p2_q, servo_p2_d;
  logic                     sat_p2_q, sat_p2_d;

  // ---- stage p0: offset removal and IIR step, all at full width ----
  always_comb begin
    acc_sum = acc_q + AW'(sample_i);
    x_p0    = XW'(sample_i) - XW'(off_q);
    diff_p0 = DW2'(x_p0) - DW2'(y_p1_q);
    step_p0 = diff_p0 >>> ALPHA_SH;
    // y moves toward x, so the sum never leaves the XW-bit range of x.
    ynew_p0 = DW2'(y_p1_q) + step_p0;
  end

  always_comb begin
    acc_d  = acc_q;
    off_d  = off_q;
    y_p1_d = y_p1_q;
    if (acc_clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      if (cal_fin_i) begin
        acc_d  = '0;
        off_d  = DATA_W'(acc_sum >>> CAL_LOG2);
        y_p1_d = '0;
      end else begin
        acc_d = acc_sum;
      end
    end
    if (run_en_i) y_p1_d = ynew_p0[XW-1:0];
  end

  // ---- stage p2: clamp of the filter state ----
  always_comb begin
    servo_p2_d = servo_p2_q;
    sat_p2_d   = sat_p2_q;
    if (out_clr_i) begin
      servo_p2_d = '0;
      sat_p2_d   = 1'b0;
    end else if (out_en_i) begin
      servo_p2_d = clamp_fn(y_p1_q);
      sat_p2_d   = sat_fn(y_p1_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q      <= '0;
      off_q      <= '0;
      y_p1_q     <= '0;
      servo_p2_q <= '0;
      sat_p2_q   <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      off_q      <= off_d;
      y_p1_q     <= y_p1_d;
      servo_p2_q <= servo_p2_d;
      sat_p2_q   <= sat_p2_d;
    end
  end

  assign servo_o = servo_p2_q;
  assign sat_o   = sat_p2_q;

endmodule

// File: rtl/gyro_servo_filter.sv
// gyro_servo_filter
//   Multi-channel gyro-to-servo path: offset calibration, IIR low-pass and
//   clamped servo output. Controller (IDLE / CAL / RUN) and calibration
//   sample counter live here; the per-channel arithmetic is gyro_chan_filter.
//   Ports:
//     clk    sole clock, rising edge
//     reset  asynchronous active-low reset
//     bus    gyro_servo_filter_if.slave (control, samples, servo outputs)
//   A sample accepted in cycle n appears on servo_out with servo_valid in
//   cycle n+2.
module gyro_servo_filter
  import gyro_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CH       = DEF_CH,
  parameter int ALPHA_SH = DEF_ALPHA_SH,
  parameter int CAL_LOG2 = DEF_CAL_LOG2,
  parameter int OUT_MIN  = DEF_OUT_MIN,
  parameter int OUT_MAX  = DEF_OUT_MAX
) (
  input  logic              clk,
  input  logic              reset,
  gyro_servo_filter_if.slave bus
);

  localparam int CW = CAL_LOG2 + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << CAL_LOG2) - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_p1_q;
  logic          servo_valid_p2_q;
  logic          cal_done_q;

  logic active, acc_clr, acc_en, cal_fin, run_stay, run_en, out_en, out_clr;
  logic cal_busy;

  logic [CH*DATA_W-1:0] servo_w;
  logic [CH-1:0]        sat_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // enable low wins over everything; cal_start always restarts calibration.
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = ST_IDLE;
    end else if (bus.cal_start) begin
      state_d = ST_CAL;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_CAL:  if (cal_fin) state_d = ST_RUN;
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A sample arriving together with a transition is dropped: 'active' is
  // false whenever the state is being redirected.
  always_comb begin
    active   = bus.enable && !bus.cal_start;
    acc_clr  = bus.enable && bus.cal_start;
    acc_en   = active && (state_q == ST_CAL) && bus.gyro_valid;
    cal_fin  = acc_en && (cnt_q == CNT_LAST);
    run_stay = active && (state_q == ST_RUN);
    run_en   = run_stay && bus.gyro_valid;
    // In-flight samples only reach the output while RUN is kept.
    out_en   = run_stay && vld_p1_q;
    out_clr  = !bus.enable;
    cal_busy = (state_q == ST_CAL);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (acc_clr)      cnt_d = '0;
    else if (cal_fin) cnt_d = '0;
    else if (acc_en)  cnt_d = cnt_q + 1'b1;
  end

  // ---- stage p1 / p2 control: valid follows the data pipeline ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q            <= '0;
      vld_p1_q         <= 1'b0;
      servo_valid_p2_q <= 1'b0;
      cal_done_q       <= 1'b0;
    end else begin
      cnt_q            <= cnt_d;
      vld_p1_q         <= run_en;
      servo_valid_p2_q <= out_en;
      cal_done_q       <= cal_fin;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_chan
    gyro_chan_filter #(
      .DATA_W  (DATA_W),
      .ALPHA_SH(ALPHA_SH),
      .CAL_LOG2(CAL_LOG2),
      .OUT_MIN (OUT_MIN),
      .OUT_MAX (OUT_MAX)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .sample_i (bus.gyro_data[i*DATA_W +: DATA_W]),
      .acc_clr_i(acc_clr),
      .acc_en_i (acc_en),
      .cal_fin_i(cal_fin),
      .run_en_i (run_en),
      .out_en_i (out_en),
      .out_clr_i(out_clr),
      .servo_o  (servo_w[i*DATA_W +: DATA_W]),
      .sat_o    (sat_w[i])
    );
  end

  assign bus.servo_out   = servo_w;
  assign bus.sat         = sat_w;
  assign bus.servo_valid = servo_valid_p2_q;
  assign bus.cal_busy    = cal_busy;
  assign bus.cal_done    = cal_done_q;

endmodule

// File: tb/tb_gyro_servo_filter.sv
// tb_gyro_servo_filter
//   Randomised and directed stimulus against a behavioural reference model;
//   expected servo outputs and cal_done pulses are queued with the cycle in
//   which they are due and compared by an independent monitor.
module tb_gyro_servo_filter;

  localparam int M_IDLE = 0;
  localparam int M_CAL  = 1;
  localparam int M_RUN  = 2;
  localparam int NCAL   = 16;
  localparam int ALPHA  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gyro_servo_filter_if #(.DATA_W(16), .CH(2)) bus ();

  gyro_servo_filter #(
    .DATA_W(16), .CH(2), .ALPHA_SH(2), .CAL_LOG2(4), .OUT_MIN(-1000), .OUT_MAX(1000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int due;
    int s0;
    int s1;
    int sat0;
    int sat1;
  } exp_t;

  exp_t exp_q[$];
  int   cal_q[$];

  // reference model state
  int   m_st = M_IDLE;
  int   m_off[2] = '{0, 0};
  int   m_y[2]   = '{0, 0};
  int   m_acc[2] = '{0, 0};
  int   m_cnt = 0;
  bit   pend_v = 1'b0;
  exp_t pend;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int fdiv(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int clampv(input int v);
    if (v < -1000) return -1000;
    if (v > 1000)  return 1000;
    return v;
  endfunction

  function automatic int ch(input int c);
    logic signed [15:0] v;
    v = bus.servo_out[c*16 +: 16];
    return int'(v);
  endfunction

  // One clock cycle: apply inputs, advance the model, then check status.
  task automatic step(input bit en, input bit cs, input bit gv, input int d0, input int d1);
    int nst;
    int d[2];
    bit stay;
    d[0] = d0;
    d[1] = d1;
    bus.enable     = en;
    bus.cal_start  = cs;
    bus.gyro_valid = gv;
    bus.gyro_data  = {16'(d1), 16'(d0)};

    nst = m_st;
    if (!en) begin
      nst = M_IDLE;
    end else if (cs) begin
      nst   = M_CAL;
      m_cnt = 0;
      m_acc = '{0, 0};
    end else if (m_st == M_IDLE) begin
      nst = M_RUN;
    end else if (m_st == M_CAL && gv) begin
      for (int c = 0; c < 2; c++) m_acc[c] += d[c];
      m_cnt++;
      if (m_cnt == NCAL) begin
        for (int c = 0; c < 2; c++) begin
          m_off[c] = fdiv(m_acc[c], NCAL);
          m_y[c]   = 0;
        end
        nst = M_RUN;
        cal_q.push_back(cyc + 1);
      end
    end

    stay = (m_st == M_RUN) && (nst == M_RUN);
    if (pend_v && stay) exp_q.push_back(pend);
    pend_v = 1'b0;
    if (stay && gv) begin
      for (int c = 0; c < 2; c++) m_y[c] += fdiv((d[c] - m_off[c]) - m_y[c], ALPHA);
      pend.due  = cyc + 2;
      pend.s0   = clampv(m_y[0]);
      pend.s1   = clampv(m_y[1]);
      pend.sat0 = (m_y[0] != clampv(m_y[0])) ? 1 : 0;
      pend.sat1 = (m_y[1] != clampv(m_y[1])) ? 1 : 0;
      pend_v    = 1'b1;
    end
    m_st = nst;

    @(posedge clk);
    #1;
    check("cal_busy", int'(bus.cal_busy), (m_st == M_CAL) ? 1 : 0);
    if (m_st == M_IDLE) begin
      check("idle_servo0", ch(0), 0);
      check("idle_servo1", ch(1), 0);
      check("idle_valid", int'(bus.servo_valid), 0);
      check("idle_sat", int'(bus.sat), 0);
    end
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b0;
    #1;
    check("rst_servo0", ch(0), 0);
    check("rst_servo1", ch(1), 0);
    check("rst_valid", int'(bus.servo_valid), 0);
    check("rst_sat", int'(bus.sat), 0);
    check("rst_cal_busy", int'(bus.cal_busy), 0);
    check("rst_cal_done", int'(bus.cal_done), 0);
    m_st   = M_IDLE;
    m_off  = '{0, 0};
    m_y    = '{0, 0};
    m_acc  = '{0, 0};
    m_cnt  = 0;
    pend_v = 1'b0;
    exp_q.delete();
    cal_q.delete();
    bus.enable     = 1'b0;
    bus.cal_start  = 1'b0;
    bus.gyro_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: compares every DUT output event against the queued expectations.
  exp_t e;
  always @(negedge clk) begin
    if (reset) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL servo_missing: got no servo_valid, required one in cycle %0d", exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (bus.servo_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL servo_unexpected: got servo_valid in cycle %0d, required none", cyc);
        end else begin
          e = exp_q.pop_front();
          check("latency", cyc, e.due);
          check("servo0", ch(0), e.s0);
          check("servo1", ch(1), e.s1);
          check("sat0", int'(bus.sat[0]), e.sat0);
          check("sat1", int'(bus.sat[1]), e.sat1);
        end
      end
      while (cal_q.size() > 0 && cal_q[0] < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL cal_done_missing: got no pulse, required one in cycle %0d", cal_q[0]);
        void'(cal_q.pop_front());
      end
      if (bus.cal_done) begin
        if (cal_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL cal_done_unexpected: got pulse in cycle %0d, required none", cyc);
        end else begin
          check("cal_done_cycle", cyc, cal_q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable     = 1'b0;
    bus.cal_start  = 1'b0;
    bus.gyro_valid = 1'b0;
    bus.gyro_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("por_servo0", ch(0), 0);
    check("por_valid", int'(bus.servo_valid), 0);
    check("por_cal_busy", int'(bus.cal_busy), 0);
    check("por_cal_done", int'(bus.cal_done), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // step response on ch0: 100, 175, 231, 273
    step(1, 0, 0, 0, 0);
    repeat (4) step(1, 0, 1, 400, 0);
    repeat (3) step(1, 0, 0, 0, 0);

    // full-scale ch1 saturates, then decays back inside the limits
    repeat (6) step(1, 0, 1, 0, 32767);
    repeat (16) step(1, 0, 1, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0);

    // asynchronous reset in the middle of RUN with samples in flight
    repeat (2) step(1, 0, 1, 300, -300);
    do_reset();

    // enable dropped with samples in flight
    step(1, 0, 0, 0, 0);
    repeat (3) step(1, 0, 1, 500, 500);
    repeat (3) step(0, 0, 1, 500, 500);

    // calibration on constant input, then the same input filters to zero
    step(1, 1, 0, 0, 0);
    repeat (16) step(1, 0, 1, 100, -50);
    step(1, 0, 0, 0, 0);
    repeat (4) step(1, 0, 1, 100, -50);
    repeat (2) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (3) step(1, 0, 1, 100, -50);
    repeat (2) step(1, 0, 0, 0, 0);

    // restart after 7 samples, restart coincident with a sample
    step(1, 1, 0, 0, 0);
    repeat (7) step(1, 0, 1, 900, 900);
    step(1, 1, 1, 900, 900);
    for (int i = 0; i < 16; i++) begin
      if (i % 5 == 2) step(1, 0, 0, 0, 0);
      step(1, 0, 1, 200 + i, -300 - i);
    end
    repeat (6) step(1, 0, 1, 500, -500);
    repeat (2) step(1, 0, 0, 0, 0);

    // randomised traffic with one mid-stream reset
    for (int i = 0; i < 600; i++) begin
      logic signed [15:0] r0, r1;
      int d0, d1;
      if (i == 300) do_reset();
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      d0 = ($urandom_range(0, 3) == 0) ? int'(r0) : int'($urandom_range(0, 4000)) - 2000;
      d1 = ($urandom_range(0, 3) == 0) ? int'(r1) : int'($urandom_range(0, 4000)) - 2000;
      step(($urandom_range(0, 29) != 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 7), d0, d1);
    end
    repeat (4) step(1, 0, 0, 0, 0);

    check("servo_queue_drained", exp_q.size(), 0);
    check("cal_queue_drained", cal_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
